branch_resolve_bht: RTL and testbench
=====================================

# branch_resolve_bht

Parametrised branch resolution unit with a direct-mapped branch history table (BHT) and branch target buffer (BTB) for the 5-stage OTTER pipeline. Fetch gets a same-cycle taken/target prediction. Execute resolves all six RV32I conditional branches, JAL, JALR, interrupt and MRET. It raises a mispredict redirect and trains the 2-bit counters on the clock edge.

## Interface
Parameters:
- XLEN, 32, datapath width of PC and operands
- BHT_DEPTH, 64, entries; power of two, >= 2; IDX = log2(BHT_DEPTH)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous reset, active-high
- IF_PC  in  XLEN  fetch PC
- PRED_TAKEN  out  1  fetch prediction: redirect to PRED_TARGET
- PRED_TARGET  out  XLEN  predicted target
- EX_VALID  in  1  execute-stage instruction valid
- EX_PC  in  XLEN  PC of execute-stage instruction
- EX_INSTR  in  32  execute-stage instruction
- EX_RS1, EX_RS2  in  XLEN  forwarded operands
- EX_BR_TGT  in  XLEN  computed branch/JAL target
- EX_PRED_TAKEN  in  1  PRED_TAKEN carried down the pipe with this instruction
- INTR  in  1  interrupt request (qualified upstream)
- MRET_EXEC  in  1  MRET in execute
- pcSource  out  3  next-PC mux select
- int_taken  out  1  interrupt accepted this cycle
- MISPREDICT  out  1  flush IF/ID and redirect
- REDIRECT_PC  out  XLEN  fall-through address EX_PC+4 (for pcSource 6)

## Operation
- Index = PC[IDX+1:2]; tag = PC[XLEN-1:IDX+2].
- Entry state: valid bit, tag, 2-bit counter (00 SN, 01 WN, 10 WT, 11 ST), target.
- Lookup: PRED_TAKEN = valid & tag match & counter[1]; PRED_TARGET = stored target (0 when PRED_TAKEN=0).
- Branch decode is opcode 1100011. Condition is selected by funct3:
  - 000 BEQ, 001 BNE
  - 100 BLT, 101 BGE (signed)
  - 110 BLTU, 111 BGEU (unsigned)
  - 010/011 are illegal and treated as not-taken.
- pcSource priority:
  1. INTR → 4, int_taken=1
  2. MRET_EXEC → 5
  3. !EX_VALID → 0
  4. JAL → 3
  5. JALR → 1
  6. branch, resolved against prediction:
     - taken & !EX_PRED_TAKEN → 2
     - !taken & EX_PRED_TAKEN → 6
     - match → 0
  7. otherwise → 0
- MISPREDICT=1 when pcSource is 1, 2, 3 or 6, or when pcSource=0 with EX_PRED_TAKEN=1 on a non-branch (stale alias).
- Training occurs on a valid branch only, and not when INTR or MRET_EXEC is high:
  - tag hit: counter saturating ±1 by outcome
  - miss & taken: allocate valid=1, tag, target, counter=10
  - miss & not-taken: no write
- Target written on every taken update.
- Illegal funct3 never trains.

## Timing
- Lookup and all execute outputs are combinational from inputs.
- BHT/BTB write occurs at the rising edge after resolution.
- Read of same index in same cycle returns pre-update contents; the new value is visible next cycle.
- RST: one cycle clears all valid bits; counters → 01, targets → 0.
  - Outputs under RST with INTR=MRET_EXEC=EX_VALID=0: PRED_TAKEN=0, PRED_TARGET=0, pcSource=0, int_taken=0, MISPREDICT=0, REDIRECT_PC=EX_PC+4.
  - Reset overrides a same-cycle training write.
- Width: EX_PC+4 wraps modulo 2^XLEN.

## Configuration
- BRU_STATS_EN defined:
  - Adds outputs BR_COUNT and MISS_COUNT (32-bit).
  - Both are saturating at 0xFFFFFFFF and cleared by RST.
  - BR_COUNT increments once per trained branch; MISS_COUNT increments for each of those with MISPREDICT=1.
- BRU_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, then IF_PC=0x100 → PRED_TAKEN=0. Then BEQ at EX_PC=0x100, RS1=RS2=5, EX_PRED_TAKEN=0, EX_BR_TGT=0x80:
  - pcSource=2, MISPREDICT=1.
  - Next cycle IF_PC=0x100 → PRED_TAKEN=1, PRED_TARGET=0x80.
- Signed vs unsigned, RS1=0xFFFFFFFF, RS2=1:
  - BLT taken (pcSource=2); BLTU not-taken (pcSource=0).
  - BGEU with EX_PRED_TAKEN=1 and RS1≥RS2 → 0, MISPREDICT=0.
- Counter saturation:
  - Four taken resolutions at one PC → counter 11.
  - One not-taken with EX_PRED_TAKEN=1 → pcSource=6, REDIRECT_PC=EX_PC+4; counter 10, still predicts taken.
  - Second not-taken → 01, PRED_TAKEN=0.
- Priority: INTR=1 with MRET_EXEC=1 and a mispredicting branch → pcSource=4, int_taken=1, MISPREDICT=0, no BHT write.
- Alias: BHT_DEPTH=4, train PC 0x10 taken, lookup PC 0x20 (same index, different tag) → PRED_TAKEN=0. RST mid-training clears the entry.
- BRU_STATS_EN: 10 branches, 3 mispredicts → BR_COUNT=10, MISS_COUNT=3. RST → both 0.

Source files
------------

// File: rtl/branch_resolve_bht.sv
// Branch resolution with direct-mapped BHT/BTB and same-cycle fetch lookup.
// Define BRU_STATS_EN to add saturating BR_COUNT / MISS_COUNT outputs.
module branch_resolve_bht #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] IF_PC,
  output logic            PRED_TAKEN,
  output logic [XLEN-1:0] PRED_TARGET,
  input  logic            EX_VALID,
  input  logic [XLEN-1:0] EX_PC,
  input  logic [31:0]     EX_INSTR,
  input  logic [XLEN-1:0] EX_RS1,
  input  logic [XLEN-1:0] EX_RS2,
  input  logic [XLEN-1:0] EX_BR_TGT,
  input  logic            EX_PRED_TAKEN,
  input  logic            INTR,
  input  logic            MRET_EXEC,
  output logic [2:0]      pcSource,
  output logic            int_taken,
  output logic            MISPREDICT,
  output logic [XLEN-1:0] REDIRECT_PC
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]     BR_COUNT,
  output logic [31:0]     MISS_COUNT
`endif
);

  localparam int IDX = $clog2(BHT_DEPTH);
  localparam int TW  = XLEN - IDX - 2;

  logic            valid_q [BHT_DEPTH];
  logic [TW-1:0]   tag_q   [BHT_DEPTH];
  logic [1:0]      ctr_q   [BHT_DEPTH];
  logic [XLEN-1:0] tgt_q   [BHT_DEPTH];

  logic [IDX-1:0] if_idx, ex_idx;
  logic [TW-1:0]  if_tag, ex_tag;
  logic [6:0]     opcode;
  logic [2:0]     f3;
  logic           is_br, is_jal, is_jalr;
  logic           br_legal, br_taken;
  logic           ex_hit, train;

  assign if_idx = IF_PC[IDX+1:2];
  assign if_tag = IF_PC[XLEN-1:IDX+2];
  assign ex_idx = EX_PC[IDX+1:2];
  assign ex_tag = EX_PC[XLEN-1:IDX+2];

  assign PRED_TAKEN = valid_q[if_idx] && (tag_q[if_idx] == if_tag)
                      && ctr_q[if_idx][1];
  assign PRED_TARGET = PRED_TAKEN ? tgt_q[if_idx] : '0;

  assign opcode  = EX_INSTR[6:0];
  assign f3      = EX_INSTR[14:12];
  assign is_br   = (opcode == 7'b1100011);
  assign is_jal  = (opcode == 7'b1101111);
  assign is_jalr = (opcode == 7'b1100111);

  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    unique case (f3)
      3'b000: br_taken = (EX_RS1 == EX_RS2);
      3'b001: br_taken = (EX_RS1 != EX_RS2);
      3'b100: br_taken = ($signed(EX_RS1) < $signed(EX_RS2));
      3'b101: br_taken = ($signed(EX_RS1) >= $signed(EX_RS2));
      3'b110: br_taken = (EX_RS1 < EX_RS2);
      3'b111: br_taken = (EX_RS1 >= EX_RS2);
      default: br_legal = 1'b0;
    endcase
  end

  always_comb begin
    pcSource  = 3'd0;
    int_taken = 1'b0;
    if (INTR) begin
      pcSource  = 3'd4;
      int_taken = 1'b1;
    end else if (MRET_EXEC) begin
      pcSource = 3'd5;
    end else if (!EX_VALID) begin
      pcSource = 3'd0;
    end else if (is_jal) begin
      pcSource = 3'd3;
    end else if (is_jalr) begin
      pcSource = 3'd1;
    end else if (is_br) begin
      if (br_taken && !EX_PRED_TAKEN)      pcSource = 3'd2;
      else if (!br_taken && EX_PRED_TAKEN) pcSource = 3'd6;
    end
  end

  // A non-branch that fetch predicted taken means the BTB aliased it
  always_comb begin
    MISPREDICT = 1'b0;
    unique case (pcSource)
      3'd1, 3'd2, 3'd3, 3'd6: MISPREDICT = 1'b1;
      3'd0: MISPREDICT = EX_VALID && EX_PRED_TAKEN && !is_br;
      default: MISPREDICT = 1'b0;
    endcase
  end

  assign REDIRECT_PC = EX_PC + XLEN'(4);

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign train  = EX_VALID && is_br && br_legal && !INTR && !MRET_EXEC;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
        tgt_q[i]   <= '0;
      end
    end else if (train) begin
      if (ex_hit) begin
        if (br_taken && ctr_q[ex_idx] != 2'b11)
          ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
        else if (!br_taken && ctr_q[ex_idx] != 2'b00)
          ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
        if (br_taken)
          tgt_q[ex_idx] <= EX_BR_TGT;
      end else if (br_taken) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        ctr_q[ex_idx]   <= 2'b10;
        tgt_q[ex_idx]   <= EX_BR_TGT;
      end
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (train && br_cnt_q != 32'hFFFF_FFFF)
      br_cnt_d = br_cnt_q + 32'd1;
    if (train && MISPREDICT && miss_cnt_q != 32'hFFFF_FFFF)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign BR_COUNT   = br_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{IF_PC[1:0], EX_PC[1:0],
                         EX_INSTR[31:15], EX_INSTR[11:7]};

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Scoreboard bench for branch_resolve_bht (BHT_DEPTH=4 so indices alias).
// Stats checks compile in only when BRU_STATS_EN is defined.
module tb_branch_resolve_bht;

  typedef struct packed {
    logic        rst;
    logic [31:0] if_pc;
    logic        v;
    logic [31:0] pc, instr, rs1, rs2, tgt;
    logic        ep, intr, mret;
  } stim_t;

  typedef struct packed {
    logic        pt;
    logic [31:0] ptgt;
    logic [2:0]  src;
    logic        it, mp;
    logic [31:0] rd;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IF_PC, EX_PC, EX_INSTR, EX_RS1, EX_RS2, EX_BR_TGT;
  logic        EX_VALID, EX_PRED_TAKEN, INTR, MRET_EXEC;
  logic        PRED_TAKEN, int_taken, MISPREDICT;
  logic [31:0] PRED_TARGET, REDIRECT_PC;
  logic [2:0]  pcSource;
`ifdef BRU_STATS_EN
  logic [31:0] BR_COUNT, MISS_COUNT;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  exp_t sb[$];

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_0067;
  localparam logic [31:0] M1   = 32'hFFFF_FFFF;

  always #5 CLK = ~CLK;

  branch_resolve_bht #(.XLEN(32), .BHT_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .IF_PC(IF_PC),
    .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
    .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_INSTR(EX_INSTR),
    .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_BR_TGT(EX_BR_TGT),
    .EX_PRED_TAKEN(EX_PRED_TAKEN), .INTR(INTR),
    .MRET_EXEC(MRET_EXEC), .pcSource(pcSource),
    .int_taken(int_taken), .MISPREDICT(MISPREDICT),
    .REDIRECT_PC(REDIRECT_PC)
`ifdef BRU_STATS_EN
    , .BR_COUNT(BR_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  function automatic logic [31:0] br(input logic [2:0] f);
    return {17'd0, f, 5'd0, 7'b1100011};
  endfunction

  function automatic stim_t S(
    input logic r, input logic [31:0] ifpc, input logic v,
    input logic [31:0] pc, ins, a, b, t,
    input logic ep, intr, mret);
    return '{r, ifpc, v, pc, ins, a, b, t, ep, intr, mret};
  endfunction

  function automatic exp_t E(
    input logic pt, input logic [31:0] ptgt, input logic [2:0] src,
    input logic it, mp, input logic [31:0] rd);
    return '{pt, ptgt, src, it, mp, rd};
  endfunction

  task automatic drive(input stim_t s);
    RST = s.rst;           IF_PC = s.if_pc;
    EX_VALID = s.v;        EX_PC = s.pc;
    EX_INSTR = s.instr;    EX_RS1 = s.rs1;
    EX_RS2 = s.rs2;        EX_BR_TGT = s.tgt;
    EX_PRED_TAKEN = s.ep;  INTR = s.intr;
    MRET_EXEC = s.mret;
  endtask

  task automatic test_reset();
    stim_t s[$]; exp_t e[$]; exp_t x, o;
    s.push_back(S(1, 32'h100, 0, 32'h200, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(0, 0, 0, 0, 0, 32'h204));
    s.push_back(S(1, 32'h100, 0, 32'hFFFF_FFFC, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(0, 0, 0, 0, 0, 32'h0));
    s.push_back(S(0, 32'h100, 0, 32'h100, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(0, 0, 0, 0, 0, 32'h104));
    for (int i = 0; i < s.size(); i++) begin
      @(posedge CLK); #1; drive(s[i]); sb.push_back(e[i]);
      @(negedge CLK); x = sb.pop_front();
      o = {PRED_TAKEN, PRED_TARGET, pcSource, int_taken, MISPREDICT, REDIRECT_PC};
      n_assert++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL reset[%0d] got pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h want pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h",
          i, o.pt, o.ptgt, o.src, o.it, o.mp, o.rd, x.pt, x.ptgt, x.src, x.it, x.mp, x.rd);
      end
    end
  endtask

  task automatic test_beq_train();
    stim_t s[$]; exp_t e[$]; exp_t x, o;
    s.push_back(S(0, 32'h100, 1, 32'h100, br(3'b000), 5, 5, 32'h80, 0, 0, 0));
    e.push_back(E(0, 0, 2, 0, 1, 32'h104));
    s.push_back(S(0, 32'h100, 0, 32'h100, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(1, 32'h80, 0, 0, 0, 32'h104));
    for (int i = 0; i < s.size(); i++) begin
      @(posedge CLK); #1; drive(s[i]); sb.push_back(e[i]);
      @(negedge CLK); x = sb.pop_front();
      o = {PRED_TAKEN, PRED_TARGET, pcSource, int_taken, MISPREDICT, REDIRECT_PC};
      n_assert++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL beq_train[%0d] got pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h want pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h",
          i, o.pt, o.ptgt, o.src, o.it, o.mp, o.rd, x.pt, x.ptgt, x.src, x.it, x.mp, x.rd);
      end
    end
  endtask

  task automatic test_signed();
    stim_t s[$]; exp_t e[$]; exp_t x, o;
    s.push_back(S(0, 32'h100, 1, 32'h304, br(3'b100), M1, 1, 32'h400, 0, 0, 0));
    e.push_back(E(1, 32'h80, 2, 0, 1, 32'h308));
    s.push_back(S(0, 32'h100, 1, 32'h308, br(3'b110), M1, 1, 32'h400, 0, 0, 0));
    e.push_back(E(1, 32'h80, 0, 0, 0, 32'h30C));
    s.push_back(S(0, 32'h100, 1, 32'h30C, br(3'b111), M1, 1, 32'h500, 1, 0, 0));
    e.push_back(E(1, 32'h80, 0, 0, 0, 32'h310));
    s.push_back(S(0, 32'h100, 1, 32'h304, br(3'b101), M1, 1, 32'h400, 1, 0, 0));
    e.push_back(E(1, 32'h80, 6, 0, 1, 32'h308));
    s.push_back(S(0, 32'h100, 1, 32'h304, br(3'b010), 5, 5, 32'h400, 1, 0, 0));
    e.push_back(E(1, 32'h80, 6, 0, 1, 32'h308));
    s.push_back(S(0, 32'h100, 1, 32'h308, br(3'b001), 5, 5, 32'h400, 0, 0, 0));
    e.push_back(E(1, 32'h80, 0, 0, 0, 32'h30C));
    s.push_back(S(0, 32'h304, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(0, 0, 0, 0, 0, 32'h4));
    s.push_back(S(0, 32'h30C, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(1, 32'h500, 0, 0, 0, 32'h4));
    for (int i = 0; i < s.size(); i++) begin
      @(posedge CLK); #1; drive(s[i]); sb.push_back(e[i]);
      @(negedge CLK); x = sb.pop_front();
      o = {PRED_TAKEN, PRED_TARGET, pcSource, int_taken, MISPREDICT, REDIRECT_PC};
      n_assert++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL signed[%0d] got pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h want pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h",
          i, o.pt, o.ptgt, o.src, o.it, o.mp, o.rd, x.pt, x.ptgt, x.src, x.it, x.mp, x.rd);
      end
    end
  endtask

  task automatic test_jump();
    stim_t s[$]; exp_t e[$]; exp_t x, o;
    s.push_back(S(0, 32'h100, 1, 32'h100, JAL, 0, 0, 32'h900, 0, 0, 0));
    e.push_back(E(1, 32'h80, 3, 0, 1, 32'h104));
    s.push_back(S(0, 32'h100, 1, 32'h100, JALR, 0, 0, 32'h900, 0, 0, 0));
    e.push_back(E(1, 32'h80, 1, 0, 1, 32'h104));
    s.push_back(S(0, 32'h100, 1, 32'h100, NOP, 0, 0, 0, 1, 0, 0));
    e.push_back(E(1, 32'h80, 0, 0, 1, 32'h104));
    s.push_back(S(0, 32'h100, 1, 32'h100, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(1, 32'h80, 0, 0, 0, 32'h104));
    s.push_back(S(0, 32'h100, 0, 32'h100, JAL, 0, 0, 32'h900, 0, 0, 0));
    e.push_back(E(1, 32'h80, 0, 0, 0, 32'h104));
    s.push_back(S(0, 32'h100, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(1, 32'h80, 0, 0, 0, 32'h4));
    for (int i = 0; i < s.size(); i++) begin
      @(posedge CLK); #1; drive(s[i]); sb.push_back(e[i]);
      @(negedge CLK); x = sb.pop_front();
      o = {PRED_TAKEN, PRED_TARGET, pcSource, int_taken, MISPREDICT, REDIRECT_PC};
      n_assert++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL jump[%0d] got pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h want pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h",
          i, o.pt, o.ptgt, o.src, o.it, o.mp, o.rd, x.pt, x.ptgt, x.src, x.it, x.mp, x.rd);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t s[$]; exp_t e[$]; exp_t x, o;
    s.push_back(S(0, 32'h208, 1, 32'h208, br(3'b000), 5, 5, 32'h600, 0, 0, 0));
    e.push_back(E(0, 0, 2, 0, 1, 32'h20C));
    s.push_back(S(0, 32'h208, 1, 32'h208, br(3'b000), 5, 5, 32'h640, 1, 0, 0));
    e.push_back(E(1, 32'h600, 0, 0, 0, 32'h20C));
    for (int k = 0; k < 2; k++) begin
      s.push_back(S(0, 32'h208, 1, 32'h208, br(3'b000), 5, 5, 32'h640, 1, 0, 0));
      e.push_back(E(1, 32'h640, 0, 0, 0, 32'h20C));
    end
    for (int k = 0; k < 2; k++) begin
      s.push_back(S(0, 32'h208, 1, 32'h208, br(3'b000), 5, 6, 32'h700, 1, 0, 0));
      e.push_back(E(1, 32'h640, 6, 0, 1, 32'h20C));
    end
    for (int k = 0; k < 2; k++) begin
      s.push_back(S(0, 32'h208, 1, 32'h208, br(3'b000), 5, 6, 32'h700, 0, 0, 0));
      e.push_back(E(0, 0, 0, 0, 0, 32'h20C));
    end
    s.push_back(S(0, 32'h208, 1, 32'h208, br(3'b000), 5, 5, 32'h600, 0, 0, 0));
    e.push_back(E(0, 0, 2, 0, 1, 32'h20C));
    s.push_back(S(0, 32'h208, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(0, 0, 0, 0, 0, 32'h4));
    for (int i = 0; i < s.size(); i++) begin
      @(posedge CLK); #1; drive(s[i]); sb.push_back(e[i]);
      @(negedge CLK); x = sb.pop_front();
      o = {PRED_TAKEN, PRED_TARGET, pcSource, int_taken, MISPREDICT, REDIRECT_PC};
      n_assert++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL saturation[%0d] got pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h want pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h",
          i, o.pt, o.ptgt, o.src, o.it, o.mp, o.rd, x.pt, x.ptgt, x.src, x.it, x.mp, x.rd);
      end
    end
  endtask

  task automatic test_priority();
    stim_t s[$]; exp_t e[$]; exp_t x, o;
    s.push_back(S(0, 32'h20C, 1, 32'h20C, br(3'b000), 5, 5, 32'h900, 0, 1, 1));
    e.push_back(E(0, 0, 4, 1, 0, 32'h210));
    s.push_back(S(0, 32'h20C, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(0, 0, 0, 0, 0, 32'h4));
    s.push_back(S(0, 32'h20C, 1, 32'h20C, br(3'b000), 5, 5, 32'h900, 0, 0, 1));
    e.push_back(E(0, 0, 5, 0, 0, 32'h210));
    s.push_back(S(0, 32'h30C, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(1, 32'h500, 0, 0, 0, 32'h4));
    s.push_back(S(0, 32'h30C, 0, 0, NOP, 0, 0, 0, 0, 1, 0));
    e.push_back(E(1, 32'h500, 4, 1, 0, 32'h4));
    for (int i = 0; i < s.size(); i++) begin
      @(posedge CLK); #1; drive(s[i]); sb.push_back(e[i]);
      @(negedge CLK); x = sb.pop_front();
      o = {PRED_TAKEN, PRED_TARGET, pcSource, int_taken, MISPREDICT, REDIRECT_PC};
      n_assert++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL priority[%0d] got pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h want pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h",
          i, o.pt, o.ptgt, o.src, o.it, o.mp, o.rd, x.pt, x.ptgt, x.src, x.it, x.mp, x.rd);
      end
    end
  endtask

  task automatic test_alias();
    stim_t s[$]; exp_t e[$]; exp_t x, o;
    s.push_back(S(0, 32'h0, 1, 32'h10, br(3'b000), 5, 5, 32'h40, 0, 0, 0));
    e.push_back(E(0, 0, 2, 0, 1, 32'h14));
    s.push_back(S(0, 32'h20, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(0, 0, 0, 0, 0, 32'h4));
    s.push_back(S(0, 32'h10, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(1, 32'h40, 0, 0, 0, 32'h4));
    s.push_back(S(1, 32'h0, 1, 32'h24, br(3'b000), 5, 5, 32'h50, 0, 0, 0));
    e.push_back(E(0, 0, 2, 0, 1, 32'h28));
    s.push_back(S(0, 32'h10, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(0, 0, 0, 0, 0, 32'h4));
    s.push_back(S(0, 32'h24, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(0, 0, 0, 0, 0, 32'h4));
    s.push_back(S(0, 32'h30C, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(0, 0, 0, 0, 0, 32'h4));
    for (int i = 0; i < s.size(); i++) begin
      @(posedge CLK); #1; drive(s[i]); sb.push_back(e[i]);
      @(negedge CLK); x = sb.pop_front();
      o = {PRED_TAKEN, PRED_TARGET, pcSource, int_taken, MISPREDICT, REDIRECT_PC};
      n_assert++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL alias[%0d] got pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h want pt=%0b tgt=%h src=%0d int=%0b mp=%0b rd=%h",
          i, o.pt, o.ptgt, o.src, o.it, o.mp, o.rd, x.pt, x.ptgt, x.src, x.it, x.mp, x.rd);
      end
    end
  endtask

`ifdef BRU_STATS_EN
  task automatic test_stats();
    stim_t s[$]; exp_t e[$]; exp_t x, o;
    s.push_back(S(0, 32'h0, 1, 32'h40, br(3'b000), 5, 5, 32'h80, 0, 0, 0));
    e.push_back(E(0, 0, 2, 0, 1, 32'h44));
    for (int k = 0; k < 7; k++) begin
      s.push_back(S(0, 32'h0, 1, 32'h40, br(3'b000), 5, 5, 32'h80, 1, 0, 0));
      e.push_back(E(0, 0, 0, 0, 0, 32'h44));
    end
    for (int k = 0; k < 2; k++) begin
      s.push_back(S(0, 32'h0, 1, 32'h40, br(3'b000), 5, 6, 32'h80, 1, 0, 0));
      e.push_back(E(0, 0, 6, 0, 1, 32'h44));
    end
    s.push_back(S(0, 32'h0, 1, 32'h40, br(3'b000), 5, 5, 32'h80, 0, 1, 0));
    e.push_back(E(0, 0, 4, 1, 0, 32'h44));
    s.push_back(S(0, 32'h0, 1, 32'h40, br(3'b011), 5, 5, 32'h80, 1, 0, 0));
    e.push_back(E(0, 0, 6, 0, 1, 32'h44));
    s.push_back(S(0, 32'h0, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    e.push_back(E(0, 0, 0, 0, 0, 32'h4));
    for (int i = 0; i < s.size(); i++) begin
      @(posedge CLK); #1; drive(s[i]); sb.push_back(e[i]);
      @(negedge CLK); x = sb.pop_front();
      o = {PRED_TAKEN, PRED_TARGET, pcSource, int_taken, MISPREDICT, REDIRECT_PC};
      n_assert++;
      if (o !== x) begin
        n_fail++;
        $display("FAIL stats[%0d] got pt=%0b src=%0d int=%0b mp=%0b want pt=%0b src=%0d int=%0b mp=%0b",
          i, o.pt, o.src, o.it, o.mp, x.pt, x.src, x.it, x.mp);
      end
    end
    n_assert++;
    if (BR_COUNT !== 32'd10 || MISS_COUNT !== 32'd3) begin
      n_fail++;
      $display("FAIL stats_count got br=%0d miss=%0d want br=10 miss=3", BR_COUNT, MISS_COUNT);
    end
    @(posedge CLK); #1;
    drive(S(1, 32'h0, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    @(posedge CLK); #1;
    drive(S(0, 32'h0, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    n_assert++;
    if (BR_COUNT !== 32'd0 || MISS_COUNT !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset got br=%0d miss=%0d want br=0 miss=0", BR_COUNT, MISS_COUNT);
    end
  endtask
`endif

  initial begin
    drive(S(1, 32'h0, 0, 0, NOP, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge CLK);
    test_reset();
    test_beq_train();
    test_signed();
    test_jump();
    test_saturation();
    test_priority();
    test_alias();
`ifdef BRU_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
